// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for a multicycle MIPS datapath. It sequences each
// instruction through FETCH, DECODE and the class-specific execute, memory
// and writeback states. It drives the datapath strobes, the mux selects and
// the 4-bit ALU operation code.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode, funct     instr[31:26] / instr[5:0] from the instruction register
//   zero              ALU zero flag, used only to resolve beq
//   pc_write, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, pc_src, alu_ctrl
//                     datapath controls (Moore, except pc_write in BRANCH
//                     and alu_ctrl in EXEC)
//   state_o           current state encoding, for debug
//   illegal           one-cycle pulse in DECODE for an unsupported opcode/funct
//   retired           count of completed instructions, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_ctrl,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // R-type funct decode, shared by the legality check in DECODE and the
    // ALU code in EXEC.
    logic       funct_legal;
    logic [3:0] r_alu_ctrl;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        funct_legal = 1'b1;
        r_alu_ctrl  = ALU_AND;
        case (funct)
            FN_ADD:  r_alu_ctrl = ALU_ADD;
            FN_SUB:  r_alu_ctrl = ALU_SUB;
            FN_AND:  r_alu_ctrl = ALU_AND;
            FN_OR:   r_alu_ctrl = ALU_OR;
            FN_SLT:  r_alu_ctrl = ALU_SLT;
            FN_NOR:  r_alu_ctrl = ALU_NOR;
            default: funct_legal = 1'b0;
        endcase
    end

    // Next state and outputs. The whole decode is gated by rst_n because
    // the reset state (FETCH) would otherwise drive its strobes while reset
    // is still asserted.
    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_AND;
        illegal    = 1'b0;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    // Speculatively compute the branch target into ALUOut.
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE: begin
                            if (funct_legal) state_d = S_EXEC;
                            else             illegal = 1'b1;
                        end
                        OP_BEQ:  state_d = S_BRANCH;
                        OP_ADDI: state_d = S_ADDIEX;
                        OP_J:    state_d = S_JUMP;
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                    state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    state_d  = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu_ctrl;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;  // unused encodings fall back to FETCH, outputs 0
            endcase
        end
    end

    // An instruction retires on the edge leaving its final state; illegal
    // instructions leave from DECODE and never count.
    always_comb begin
        retired_d = retired_q;
        if (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP})
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of statement order.
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Scoreboard bench for mips_multicycle_ctrl. The driver expands each issued
// instruction into its expected per-cycle observation using the documented
// instruction classes. Each observation is pushed to a queue. A separate
// monitor pops one entry per falling edge and compares it to the DUT.
// CNT_W is 4 so the retired counter wraps during the run.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode, funct;
    logic             zero;
    logic             pc_write, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, pc_src;
    logic [3:0]       alu_ctrl, state_o;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .state_o    (state_o),
        .illegal    (illegal),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pc_write;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       pc_src;
        logic [3:0]       alu_ctrl;
        logic [3:0]       state;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } obs_t;

    typedef enum { K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_ILL } kind_t;

    obs_t             sb[$];
    int               vectors     = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] retired_m   = '0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.pc_write   = pc_write;
        o.iord       = iord;
        o.mem_read   = mem_read;
        o.mem_write  = mem_write;
        o.ir_write   = ir_write;
        o.reg_dst    = reg_dst;
        o.mem_to_reg = mem_to_reg;
        o.reg_write  = reg_write;
        o.alu_src_a  = alu_src_a;
        o.alu_src_b  = alu_src_b;
        o.pc_src     = pc_src;
        o.alu_ctrl   = alu_ctrl;
        o.state      = state_o;
        o.illegal    = illegal;
        o.retired    = retired;
        return o;
    endfunction

    // Reference decode: instruction class and R-type ALU code.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100,
                                          6'b100101, 6'b101010, 6'b100111}) ? K_R : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_code(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0101;
        endcase
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e = '0;
        e.state   = st;
        e.retired = retired_m;
        return e;
    endfunction

    // Queue one expected cycle, then advance to just after the next edge.
    task automatic push_cycle(input obs_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction. When abort_memrd is set, the instruction must
    // be a lw. Reset is then pulsed for one cycle during its MEMRD cycle.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input bit abort_memrd);
        obs_t  e;
        kind_t k = classify(op, fn);
        opcode = op;
        funct  = fn;
        zero   = z;

        e = blank(4'd0);
        e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010;
        push_cycle(e);

        e = blank(4'd1);
        e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; e.illegal = (k == K_ILL);
        push_cycle(e);

        case (k)
            K_LW, K_SW: begin
                e = blank(4'd2);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010;
                push_cycle(e);
                if (k == K_LW) begin
                    e = blank(4'd3);
                    e.mem_read = 1'b1; e.iord = 1'b1;
                    if (abort_memrd) begin
                        sb.push_back(e);
                        @(negedge clk);
                        #2 rst_n = 1'b0;
                        #1 check("async_reset_memrd", dut_obs(), obs_t'(0));
                        @(posedge clk);
                        #1 check("reset_held_edge", dut_obs(), obs_t'(0));
                        rst_n     = 1'b1;
                        retired_m = '0;
                        return;
                    end
                    push_cycle(e);
                    e = blank(4'd4);
                    e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    push_cycle(e);
                end else begin
                    e = blank(4'd5);
                    e.mem_write = 1'b1; e.iord = 1'b1;
                    push_cycle(e);
                end
            end
            K_R: begin
                e = blank(4'd6);
                e.alu_src_a = 1'b1; e.alu_ctrl = r_code(fn);
                push_cycle(e);
                e = blank(4'd7);
                e.reg_write = 1'b1; e.reg_dst = 1'b1;
                push_cycle(e);
            end
            K_BEQ: begin
                e = blank(4'd8);
                e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0110; e.pc_src = 2'b01;
                e.pc_write = z;
                push_cycle(e);
            end
            K_ADDI: begin
                e = blank(4'd9);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010;
                push_cycle(e);
                e = blank(4'd10);
                e.reg_write = 1'b1;
                push_cycle(e);
            end
            K_J: begin
                e = blank(4'd11);
                e.pc_write = 1'b1; e.pc_src = 2'b10;
                push_cycle(e);
            end
            default: ;
        endcase
        if (k != K_ILL) retired_m = retired_m + 1'b1;
    endtask

    // Monitor: one observation per active cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sb.size() > 0) begin
                obs_t exp;
                exp = sb.pop_front();
                check($sformatf("cycle_state%0d", exp.state), dut_obs(), exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0] r_functs[6];
    logic [5:0] op_r, fn_r;

    initial begin
        r_functs[0] = 6'b100000; r_functs[1] = 6'b100010; r_functs[2] = 6'b100100;
        r_functs[3] = 6'b100101; r_functs[4] = 6'b101010; r_functs[5] = 6'b100111;
        rst_n  = 1'b0;
        opcode = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b1;

        // Reset state: the FETCH state drives no strobes while rst_n is low.
        repeat (2) @(posedge clk);
        #3 check("reset_outputs", dut_obs(), obs_t'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // lw from reset, then lw aborted by reset in MEMRD, then lw again.
        issue(6'b100011, 6'b000000, 1'b0, 1'b0);
        issue(6'b100011, 6'b000000, 1'b0, 1'b1);
        issue(6'b100011, 6'b000000, 1'b0, 1'b0);

        // R-type stream over every supported funct.
        for (int i = 0; i < 6; i++) issue(6'b000000, r_functs[i], 1'b0, 1'b0);

        // beq taken / not taken, sw, addi.
        issue(6'b000100, 6'b000000, 1'b1, 1'b0);
        issue(6'b000100, 6'b000000, 1'b0, 1'b0);
        issue(6'b101011, 6'b000000, 1'b1, 1'b0);
        issue(6'b001000, 6'b000000, 1'b1, 1'b0);

        // Illegal opcode and illegal R-type funct.
        issue(6'b111111, 6'b100000, 1'b0, 1'b0);
        issue(6'b000000, 6'b000000, 1'b0, 1'b0);

        // 17 consecutive jumps wrap the 4-bit retired counter.
        for (int i = 0; i < 17; i++) issue(6'b000010, 6'($urandom), 1'($urandom), 1'b0);

        // Randomized instruction mix.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       op_r = 6'b100011;
                1:       op_r = 6'b101011;
                2, 3:    op_r = 6'b000000;
                4:       op_r = 6'b000100;
                5:       op_r = 6'b001000;
                6:       op_r = 6'b000010;
                default: op_r = 6'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0) fn_r = r_functs[$urandom_range(0, 5)];
            else                           fn_r = 6'($urandom);
            issue(op_r, fn_r, 1'($urandom), (op_r == 6'b100011) && ($urandom_range(0, 19) == 0));
        end

        // Every queued expectation must have been consumed by the monitor.
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
